if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 26 ++
 rtl/if_fetch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared state encoding, reset PC and address helpers for if_fetch
package if_fetch_pkg;

   // Fetch FSM state encoding
   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_REQ  = 2'd1,
      IF_WAIT = 2'd2
   } if_state_e;

   // Default first fetch address after reset
   localparam logic [31:0] IF_RESET_PC_DEF = 32'h0000_0000;

   // Sequential fetch stride (one 32-bit instruction)
   localparam logic [31:0] IF_PC_STEP = 32'd4;

   // Branch / jump type codes shared with decode and execute
   localparam logic [2:0] IF_BTYPE_CODE = 3'b110;
   localparam logic [2:0] IF_JTYPE_CODE = 3'b111;

   // Force a target onto a word boundary
   function automatic logic [31:0] if_word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch FSM, one outstanding Icache request; optional IF_MISALIGN_EXC_EN adds if_misalign_o
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fc_bk_if_i,
   input  logic        id_jump_flag_i,
   input  logic [31:0] id_jump_pc_i,
   input  logic        ex_btype_flag_i,
   input  logic [31:0] ex_btype_pc_i,
   input  logic        Icache_ready_i,
   input  logic        Icache_data_valid_i,
   output logic        if_req_o,
   output logic [31:0] if_addr_o,
   output logic [31:0] if_pc_o,
   output logic        if_inst_valid_o
`ifdef IF_MISALIGN_EXC_EN
   ,
   output logic        if_misalign_o
`endif
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        kill_q, kill_d;
   logic        redirect;
   logic [31:0] target;
   logic        fetch_en;
   logic        accept;

`ifdef IF_MISALIGN_EXC_EN
   logic        misalign_q, misalign_d;
   logic        tgt_misaligned;
`endif

   // Redirect selection: the branch from execute is older than the jump from decode
   always_comb begin
      redirect = ex_btype_flag_i | id_jump_flag_i;
`ifdef IF_MISALIGN_EXC_EN
      target         = ex_btype_flag_i ? ex_btype_pc_i : id_jump_pc_i;
      tgt_misaligned = (target[1:0] != 2'b00);
`else
      target = if_word_align(ex_btype_flag_i ? ex_btype_pc_i : id_jump_pc_i);
`endif
   end

   // Next-state, PC update and Icache handshake outputs
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      if_pc_d         = if_pc_q;
      kill_d          = kill_q;
      if_req_o        = 1'b0;
      if_inst_valid_o = 1'b0;
      accept          = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
      misalign_d      = misalign_q;
      fetch_en        = ~fc_bk_if_i & ~misalign_q;
      if (redirect) begin
         misalign_d = tgt_misaligned;
      end
`else
      fetch_en        = ~fc_bk_if_i;
`endif

      case (state_q)
         IF_IDLE: begin
            state_d = IF_REQ;
         end

         IF_REQ: begin
            if_req_o = fetch_en;
            accept   = fetch_en & Icache_ready_i;
            if (accept) begin
               state_d = IF_WAIT;
               if_pc_d = pc_q;
               // A redirect racing the accept makes the launched fetch stale
               if (redirect) begin
                  kill_d = 1'b1;
               end
            end
            if (redirect) begin
               pc_d = target;
            end
         end

         IF_WAIT: begin
            if (Icache_data_valid_i) begin
               state_d = IF_REQ;
               kill_d  = 1'b0;
               if (redirect) begin
                  pc_d = target;
               end else if (!kill_q) begin
                  pc_d            = if_pc_q + IF_PC_STEP;
                  if_inst_valid_o = 1'b1;
               end
               // Killed response: pc already holds the redirect target
            end else if (redirect) begin
               kill_d = 1'b1;
               pc_d   = target;
            end
         end

         default: begin
            state_d = IF_IDLE;
         end
      endcase
   end

   // State, PC and kill registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IF_IDLE;
         pc_q    <= RESET_PC;
         if_pc_q <= RESET_PC;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if_pc_q <= if_pc_d;
         kill_q  <= kill_d;
      end
   end

`ifdef IF_MISALIGN_EXC_EN
   // Misaligned-target flag, cleared by the next aligned redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign if_misalign_o = misalign_q;
`endif

   assign if_addr_o = pc_q;
   assign if_pc_o   = if_pc_q;

endmodule
